vx_imem_responder: RTL and testbench
====================================

Name: vx_imem_responder

Overview:
Memory-side responder for the instruction fetch bus. It accepts read and write requests on the fetch request channel (addr, tag, rw, byteen, data) and returns in-order read responses (data, tag) after a fixed pipeline latency. A credit counter guarantees every accepted read has a response-queue slot, so the pipeline never stalls internally. It is used as the icache stand-in for core-level simulation, and as the boot ROM/RAM behind the fetch unit when L1 is disabled.

Parameters:
ADDR_WIDTH, 30, word-address width of req_addr
DATA_WIDTH, 32, word width; byteen width = DATA_WIDTH/8
TAG_WIDTH, 8, request/response tag width (uuid + wid), returned unmodified
SIZE, 4096, memory depth in words (power of two)
LATENCY, 2, request-fire to rsp_valid cycles when queue empty (>=1)
RSP_QUEUE_SIZE, 4, max outstanding reads (in pipeline + queued), >= LATENCY
INIT_FILE, "", hex preload file; empty = memory contents undefined

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_rw  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_byteen  in  DATA_WIDTH/8  write byte enables
req_data  in  DATA_WIDTH  write data
req_tag  in  TAG_WIDTH  request tag
req_ready  out  1  request accepted when valid&&ready
rsp_valid  out  1  response valid
rsp_data  out  DATA_WIDTH  read data
rsp_tag  out  TAG_WIDTH  tag of the originating read
rsp_ready  in  1  response consumer ready

Behaviour:
- Reset (reset low, async): rsp_valid=0, req_ready=0 while asserted, credit count=0, pipeline valids cleared, queue emptied. rsp_data and rsp_tag are don't-care. Memory contents are not cleared.
- After reset deasserts: req_ready = (count < RSP_QUEUE_SIZE), purely from registered count. It does not depend on req_valid or rsp_ready.
- Index: req_addr[log2(SIZE)-1:0]. Upper address bits are ignored, so addresses wrap modulo SIZE.
- Write fire: memory bytes with req_byteen=1 are updated on that edge. No response is generated and count is unchanged. A read of the same word in the next cycle returns the new data.
- Read fire: count+1; tag and valid enter a LATENCY-deep pipeline alongside the synchronous memory read.
- Pipeline output pushes into a FWFT queue of depth RSP_QUEUE_SIZE. When the queue is empty, the entry bypasses it, so rsp_valid rises exactly LATENCY cycles after fire.
- Response fire (rsp_valid&&rsp_ready): queue pop, count-1.
- Read fire and response fire in the same cycle: count unchanged.
- Queue full with the pipeline still delivering cannot occur, because of the credit rule. An assertion flags any push into a full queue.
- Ordering: responses strictly follow read-acceptance order. The tag is returned bit-exact.
- Back-to-back reads at one per cycle are sustained indefinitely when rsp_ready=1.
- rsp_valid, rsp_data and rsp_tag hold stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: all in-flight and queued reads are dropped and count=0. No stale response appears after reset deasserts.
- Count width: clog2(RSP_QUEUE_SIZE+1). It never underflows (assertion on pop when count=0).

Optional Feature:
IMEM_RSP_PERF_EN
- Defined: adds outputs perf_reads (32b, reads accepted), perf_writes (32b, writes accepted) and perf_stalls (32b, cycles with req_valid=1 and req_ready=0). All three clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Preload word 0x10=0x00000513, read tag 0x2A with rsp_ready=1 -> rsp_valid exactly 2 cycles after fire, rsp_data=0x00000513, rsp_tag=0x2A.
- 8 back-to-back reads of addrs 0..7 with tags 0..7, rsp_ready=1 -> 8 consecutive response cycles, in order, tags 0..7; req_ready stays 1.
- rsp_ready=0, issue reads -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> 4 in-order responses, with data stable while stalled; req_ready returns to 1 the cycle after the first pop.
- Write addr 0x20 data 0xDEADBEEF byteen 4'b0011 over 0x11111111, then read next cycle -> rsp_data=0x1111BEEF; no response generated for the write.
- Read addr SIZE+5 -> returns word 5 (wrap).
- Assert reset low with 3 reads in flight -> rsp_valid drops immediately. After release, no responses appear, count=0, req_ready=1.

Source files
------------

// File: rtl/vx_imem_responder.sv
// vx_imem_responder: word-addressed fetch-bus memory returning in-order read responses
// after a fixed latency. Define IMEM_RSP_PERF_EN to add read/write/stall counters.
module vx_imem_responder #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int SIZE           = 4096,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  parameter     INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_byteen,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  input  logic                    rsp_ready
`ifdef IMEM_RSP_PERF_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_QUEUE_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_QUEUE_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [IDX_W-1:0]      idx;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_fire;
  logic [CNT_W-1:0]      count;

  logic [LATENCY-1:0]    pipe_v;
  logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic                  pipe_out_v;

  logic [DATA_WIDTH-1:0] q_data [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  q_tag  [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      q_cnt;
  logic                  q_empty;
  logic                  q_full;
  logic                  push;
  logic                  pop;

  // The hex image is loaded into mem by the simulation/emulation loader flow,
  // which addresses the array hierarchically; only the name is carried here.
  logic unused_init;
  assign unused_init = (INIT_FILE != "");

  if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W];
  end

  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = reset && (count < CNT_MAX);
  assign rd_fire   = req_valid && req_ready && !req_rw;
  assign wr_fire   = req_valid && req_ready && req_rw;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  // Credits: one per accepted read, returned when its response is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      pipe_data[0] <= mem[idx];
      pipe_tag[0]  <= req_tag;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  assign pipe_out_v = pipe_v[LATENCY-1];
  assign q_empty    = (q_cnt == '0);
  assign q_full     = (q_cnt == CNT_MAX);

  // An empty queue with a ready consumer is bypassed so latency stays fixed.
  assign push = pipe_out_v && !(q_empty && rsp_ready);
  assign pop  = !q_empty && rsp_ready;

  assign rsp_valid = !q_empty || pipe_out_v;
  assign rsp_data  = q_empty ? pipe_data[LATENCY-1] : q_data[rd_ptr];
  assign rsp_tag   = q_empty ? pipe_tag[LATENCY-1]  : q_tag[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= pipe_data[LATENCY-1];
      q_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && q_full));
  a_no_credit_underflow: assert property (@(posedge clk) disable iff (!reset)
                                          !(rsp_fire && (count == '0)));

`ifdef IMEM_RSP_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire) perf_reads <= perf_reads + 32'd1;
      if (wr_fire) perf_writes <= perf_writes + 32'd1;
      if (req_valid && !req_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_imem_responder.sv
// Scoreboard bench for vx_imem_responder: driver pushes expected read responses,
// a negedge monitor pops and compares them, and also checks stall stability.
module tb_vx_imem_responder;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int SZ = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [3:0]    req_byteen = '0;
  logic [DW-1:0] req_data = '0;
  logic [TW-1:0] req_tag = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready = 1'b1;

  vx_imem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .SIZE(SZ),
    .LATENCY(2), .RSP_QUEUE_SIZE(4), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int rsp_fires = 0;
  int run_len = 0;
  int max_run = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic [TW-1:0] stall_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: scoreboard pop on every response fire, hold check while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
        run_len = 0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", rsp_valid, 1);
          check("stall_data", rsp_data, stall_data);
          check("stall_tag", rsp_tag, stall_tag);
        end
        stall_prev = rsp_valid && !rsp_ready;
        stall_data = rsp_data;
        stall_tag  = rsp_tag;
        if (rsp_valid && rsp_ready) begin
          rsp_fires++;
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_tag", rsp_tag, e.tag);
          end
        end else begin
          run_len = 0;
        end
      end
    end
  end

  // Called and returns at #1 after a rising edge; the request fires on the edge in between.
  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [3:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag,
                       input logic [DW-1:0] exp_data, output int waited);
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
    end else begin
      req_valid = 1'b1; req_rw = rw; req_addr = addr;
      req_byteen = be; req_data = data; req_tag = tag;
      if (!rw) exp_q.push_back('{exp_data, tag});
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || rsp_valid) && n < 100);
    if (exp_q.size() != 0 || rsp_valid) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    int w;
    int wsum;
    int f;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;

    // Preload through the bus: words 0..7, 0x10 and 0x20.
    for (int i = 0; i < 8; i++) issue(1, AW'(i), 4'hF, 32'hA5A5_0000 | i, 8'h00, '0, w);
    issue(1, 30'h10, 4'hF, 32'h0000_0513, 8'h00, '0, w);
    issue(1, 30'h20, 4'hF, 32'h1111_1111, 8'h00, '0, w);
    drain();
    check("writes_no_rsp", rsp_fires, 0);

    // Fixed latency with an empty queue.
    issue(0, 30'h10, 4'h0, '0, 8'h2A, 32'h0000_0513, w);
    @(negedge clk);
    check("lat_one_cycle_low", rsp_valid, 0);
    @(negedge clk);
    check("lat_two_cycles_high", rsp_valid, 1);
    drain();

    // Back-to-back reads at full rate.
    max_run = 0;
    f = rsp_fires;
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      issue(0, AW'(i), 4'h0, '0, TW'(i), 32'hA5A5_0000 | i, w);
      wsum += w;
    end
    check("b2b_ready_waits", wsum, 0);
    drain();
    check("b2b_consecutive", max_run, 8);
    check("b2b_count", rsp_fires - f, 8);

    // Credit limit with a stalled consumer.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(0, AW'(3 - i), 4'h0, '0, TW'(8'h40 + i), 32'hA5A5_0000 | (3 - i), w);
      check("credit_accept_wait", w, 0);
    end
    check("credit_full", req_ready, 0);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 30'h0; req_tag = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
      check("credit_hold", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("ready_before_pop", req_ready, 0);
    @(posedge clk); #1;
    check("ready_after_pop", req_ready, 1);
    drain();

    // Partial-byte write then immediate read of the same word.
    f = rsp_fires;
    issue(1, 30'h20, 4'b0011, 32'hDEAD_BEEF, 8'h00, '0, w);
    issue(0, 30'h20, 4'h0, '0, 8'h77, 32'h1111_BEEF, w);
    drain();
    check("partial_write_rsps", rsp_fires - f, 1);

    // Address wrap modulo SIZE.
    issue(0, AW'(SZ + 5), 4'h0, '0, 8'h55, 32'hA5A5_0005, w);
    issue(0, 30'h3FFF_F007, 4'h0, '0, 8'h56, 32'hA5A5_0007, w);
    drain();

    // Reset with reads in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(0, AW'(i), 4'h0, '0, TW'(8'h90 + i), 32'hA5A5_0000 | i, w);
    check("pre_rst_valid", rsp_valid, 1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    f = rsp_fires;
    #1;
    check("rel_req_ready", req_ready, 1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("no_stale_rsp", rsp_fires - f, 0);
    check("no_stale_valid", rsp_valid, 0);

    // Credits restart at zero and memory survives reset.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 30'h10, 4'h0, '0, TW'(8'hB0 + i), 32'h0000_0513, w);
      check("rst_credit_wait", w, 0);
    end
    check("rst_credit_full", req_ready, 0);
    rsp_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
